// File: rtl/serial_subtractor_nand_pkg.sv
// Shared definitions for the bit-serial NAND subtractor: FSM encoding and default width.
package serial_subtractor_nand_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_nand_if.sv
// Requester/consumer bus of the serial subtractor: operands and start in, result and status out.
interface serial_subtractor_nand_if #(
  parameter int unsigned WIDTH = serial_subtractor_nand_pkg::DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_subtractor_nand.sv
// One-bit full subtractor x - y - bin built only from 2-input NAND gates.
module full_subtractor_nand (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire n1, n2, n3, t;
  wire m1, m2, m3;
  wire nx, nt, p, q;

  // t = x ^ y
  nand g_n1 (n1, x, y);
  nand g_n2 (n2, x, n1);
  nand g_n3 (n3, y, n1);
  nand g_t  (t, n2, n3);

  // d = t ^ bin
  nand g_m1 (m1, t, bin);
  nand g_m2 (m2, t, m1);
  nand g_m3 (m3, bin, m1);
  nand g_d  (d, m2, m3);

  // bout = (~x & y) | (~t & bin)
  nand g_nx (nx, x, x);
  nand g_nt (nt, t, t);
  nand g_p  (p, nx, y);
  nand g_q  (q, nt, bin);
  nand g_bo (bout, p, q);

endmodule

// File: rtl/serial_subtractor_nand.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one bit per clock, done pulse on completion.
module serial_subtractor_nand
  import serial_subtractor_nand_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_nand_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, diff_q;
  logic             brw, bout_q, busy_q, done_q;
  logic [CW-1:0]    cnt;
  logic             load_c, step_c, last_c;
  logic             d_bit, brw_nxt;

  full_subtractor_nand u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (brw),
    .d    (d_bit),
    .bout (brw_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load_c  = 1'b0;
    step_c  = 1'b0;
    last_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_c = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and result registers; diff/bout only update on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      if (load_c) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        d_sh <= '0;
        brw  <= bus.bin;
        cnt  <= '0;
      end
      if (step_c) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        d_sh <= {d_bit, d_sh[WIDTH-1:1]};
        brw  <= brw_nxt;
        cnt  <= cnt + CW'(1);
      end
      if (last_c) begin
        diff_q <= {d_bit, d_sh[WIDTH-1:1]};
        bout_q <= brw_nxt;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
